// File: rtl/hexscroll_ctrl.sv
// hexscroll_ctrl
//   Scroll controller for an 8-digit hex display. It produces the base digit
//   index (pos) that the display datapath starts from. In RUN, pos advances
//   one step every PRESCALE clocks, in the direction given by dir.
//
//   Optional feature macro: HEXSCROLL_STEP_EN
//     Defined   : a step rising edge in IDLE or PAUSE advances pos by one.
//     Undefined : the step port is present but ignored.
//
//   Parameters
//     PRESCALE  : clock cycles per scroll step (2..2^26)
//     WIDTH_CNT : prescaler counter width; must hold PRESCALE-1
//
//   Ports
//     clk      : system clock, rising edge
//     rst_n    : asynchronous active-low reset
//     start    : level input; a rising edge enters RUN (from IDLE or PAUSE)
//     stop     : level input; a rising edge goes RUN->PAUSE or PAUSE->IDLE
//     dir      : 0 = pos increments, 1 = pos decrements (sampled at advance)
//     step     : level input; a rising edge single-steps pos (feature macro)
//     load     : synchronous load strobe, acted on every cycle it is high
//     load_val : value written to pos on load
//     pos      : registered base digit index, 0..7
//     running  : high while in RUN
//     wrap     : one-cycle pulse after pos wraps 7->0 or 0->7
module hexscroll_ctrl #(
  parameter int unsigned PRESCALE  = 50000000,
  parameter int unsigned WIDTH_CNT = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       step,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] pos,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [WIDTH_CNT-1:0] CNT_LAST = WIDTH_CNT'(PRESCALE - 1);

  state_t               state;
  logic [WIDTH_CNT-1:0] cnt;
  logic                 start_q;
  logic                 stop_q;
  logic                 start_rise;
  logic                 stop_rise;

  // An edge is acted on at the same clock edge where the input is first
  // seen high; the _q registers hold the previous sample.
  assign start_rise = start & ~start_q;
  assign stop_rise  = stop  & ~stop_q;

  function automatic logic [2:0] next_pos(input logic [2:0] p, input logic d);
    return d ? (p - 3'd1) : (p + 3'd1);
  endfunction

  function automatic logic crosses(input logic [2:0] p, input logic d);
    return d ? (p == 3'd0) : (p == 3'd7);
  endfunction

`ifdef HEXSCROLL_STEP_EN
  logic step_q;
  logic step_rise;

  assign step_rise = step & ~step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end
`else
  logic unused_step;
  assign unused_step = step;
`endif

  // Priority per cycle: load > stop edge > start edge > step edge > tick.
  // An event that has no effect in the current state does not block a
  // lower-priority event (e.g. a start edge in RUN leaves counting alone).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pos     <= '0;
      cnt     <= '0;
      wrap    <= 1'b0;
      running <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      wrap    <= 1'b0;

      if (load) begin
        pos <= load_val;
        cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_rise) begin
              state   <= RUN;
              running <= 1'b1;
              cnt     <= '0;
            end
`ifdef HEXSCROLL_STEP_EN
            else if (step_rise) begin
              pos  <= next_pos(pos, dir);
              wrap <= crosses(pos, dir);
            end
`endif
          end

          RUN: begin
            if (stop_rise) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              cnt  <= '0;
              pos  <= next_pos(pos, dir);
              wrap <= crosses(pos, dir);
            end else begin
              cnt <= cnt + WIDTH_CNT'(1);
            end
          end

          PAUSE: begin
            if (stop_rise) begin
              state <= IDLE;
              pos   <= '0;
              cnt   <= '0;
            end else if (start_rise) begin
              // cnt is kept, so counting resumes where it was frozen
              state   <= RUN;
              running <= 1'b1;
            end
`ifdef HEXSCROLL_STEP_EN
            else if (step_rise) begin
              pos  <= next_pos(pos, dir);
              wrap <= crosses(pos, dir);
            end
`endif
          end

          default: begin
            state   <= IDLE;
            running <= 1'b0;
            cnt     <= '0;
          end
        endcase
      end
    end
  end

endmodule
